// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The fetch unit drives requests (master); the memory returns in-order responses (slave).
interface if_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: credit-limited imem requests, in-order response queue toward decode,
// redirect flushes the queue and discards responses still owed from the old path.
module if_fetch #(
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  if_fetch_if.master  imem,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int          CW       = $clog2(QDEPTH + 1);
  localparam int          PW       = $clog2(QDEPTH);
  localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic [PW-1:0] q_wr_ptr_reg, q_wr_ptr_next;
  logic [PW-1:0] q_rd_ptr_reg, q_rd_ptr_next;
  logic [PW-1:0] pend_wr_ptr_reg, pend_wr_ptr_next;
  logic [PW-1:0] pend_rd_ptr_reg, pend_rd_ptr_next;

  logic [31:0]   q_pc_reg    [QDEPTH];
  logic [31:0]   q_instr_reg [QDEPTH];
  logic [31:0]   pend_pc_reg [QDEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Queued entries plus requests still owed a response may never exceed the queue size.
  assign credit_used         = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign imem.imem_req_valid = ~reset & (credit_used < QDEPTH_W);
  assign imem.imem_req_addr  = fetch_pc_reg;

  assign instr_valid = ~reset & (count_reg != '0);
  assign instr       = instr_valid ? q_instr_reg[q_rd_ptr_reg] : 32'h0;
  assign instr_pc    = instr_valid ? q_pc_reg[q_rd_ptr_reg]    : 32'h0;

  assign req_fire = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_fire = imem.imem_rsp_valid;
  assign pop      = instr_valid & instr_ready;
  assign push     = rsp_fire & (drop_reg == '0) & ~redirect_en;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_next    = inflight_reg + CW'(req_fire) - CW'(rsp_fire);
    drop_next        = drop_reg - CW'(rsp_fire && (drop_reg != '0));
    count_next       = count_reg + CW'(push) - CW'(pop);
    q_wr_ptr_next    = q_wr_ptr_reg + PW'(push);
    q_rd_ptr_next    = q_rd_ptr_reg + PW'(pop);
    pend_wr_ptr_next = pend_wr_ptr_reg + PW'(req_fire);
    pend_rd_ptr_next = pend_rd_ptr_reg + PW'(rsp_fire);

    if (req_fire) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    // Every request still outstanding after this cycle belongs to the old path.
    if (redirect_en) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      count_next    = '0;
      q_wr_ptr_next = '0;
      q_rd_ptr_next = '0;
      drop_next     = inflight_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      count_reg       <= '0;
      inflight_reg    <= '0;
      drop_reg        <= '0;
      q_wr_ptr_reg    <= '0;
      q_rd_ptr_reg    <= '0;
      pend_wr_ptr_reg <= '0;
      pend_rd_ptr_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      count_reg       <= count_next;
      inflight_reg    <= inflight_next;
      drop_reg        <= drop_next;
      q_wr_ptr_reg    <= q_wr_ptr_next;
      q_rd_ptr_reg    <= q_rd_ptr_next;
      pend_wr_ptr_reg <= pend_wr_ptr_next;
      pend_rd_ptr_reg <= pend_rd_ptr_next;
    end
  end

  // Storage is data-only; validity is tracked by the counters and pointers above.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (q_wr_ptr_reg == PW'(gi))) begin
        q_pc_reg[gi]    <= pend_pc_reg[pend_rd_ptr_reg];
        q_instr_reg[gi] <= imem.imem_rsp_data;
      end
      if (req_fire && (pend_wr_ptr_reg == PW'(gi))) begin
        pend_pc_reg[gi] <= fetch_pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed corner sequences, a redirect vector table,
// and a randomized run scored against a program-order reference of expected fetch PCs.
module tb_if_fetch;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  if_fetch_if bus ();

  if_fetch #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  mreq_t       memq[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  int          rdy_pct = 100, ir_pct = 100;
  bit          arm_both = 0, armed_fired = 0;
  logic [31:0] arm_pc = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  int          req_hs_cnt = 0, pop_cnt = 0;
  logic [31:0] last_pop_pc = 32'h0;
  bit          prev_req_pending = 0, prev_instr_pending = 0;
  logic [31:0] prev_addr, prev_instr, prev_ipc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock of stimulus: memory model, decode model and program-order scoreboard.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    mreq_t m;
    bit    req_hs, rsp;
    @(negedge clk);
    cyc++;
    redirect_en = redir;
    redirect_pc = rpc;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    instr_ready = ($urandom_range(99) < ir_pct);
    #1;
    if (arm_both && bus.imem_rsp_valid && bus.imem_req_valid && bus.imem_req_ready) begin
      redirect_en = 1'b1;
      redirect_pc = arm_pc;
      arm_both    = 0;
      armed_fired = 1;
    end
    if (!reset) begin
      if (bus.imem_req_valid) chk("req_addr_align", {30'h0, bus.imem_req_addr[1:0]}, 32'h0);
      if (prev_req_pending) begin
        chk("req_valid_hold", 32'(bus.imem_req_valid), 32'h1);
        chk("req_addr_hold", bus.imem_req_addr, prev_addr);
      end
      if (prev_instr_pending) begin
        chk("instr_valid_hold", 32'(instr_valid), 32'h1);
        chk("instr_hold", instr, prev_instr);
        chk("instr_pc_hold", instr_pc, prev_ipc);
      end
      if (instr_valid && instr_ready) begin
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr_data", instr, mem_word(exp_pc));
        exp_pc      = exp_pc + 32'd4;
        pop_cnt++;
        last_pop_pc = instr_pc;
      end
      if (redirect_en) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    prev_req_pending   = !reset && bus.imem_req_valid && !bus.imem_req_ready && !redirect_en;
    prev_addr          = bus.imem_req_addr;
    prev_instr_pending = !reset && instr_valid && !instr_ready && !redirect_en;
    prev_instr         = instr;
    prev_ipc           = instr_pc;
    req_hs             = !reset && bus.imem_req_valid && bus.imem_req_ready;
    rsp                = bus.imem_rsp_valid;
    @(posedge clk);
    if (reset) begin
      memq.delete();
    end else begin
      if (req_hs) begin
        chk("credit_limit", 32'(memq.size() < QDEPTH), 32'h1);
        req_hs_cnt++;
      end
      if (rsp) m = memq.pop_front();
      if (req_hs) begin
        m.addr = bus.imem_req_addr;
        m.due  = cyc + $urandom_range(lat_max, lat_min);
        memq.push_back(m);
      end
    end
  endtask

  task automatic drain(input int n);
    rdy_pct = 0;
    ir_pct  = 100;
    repeat (n) cycle(0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   p0, h0, waited;

    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    vecs[3] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567C};
    vecs[4] = '{32'h8000_0FFE, 32'h8000_0FFC, 32'h8000_1000};
    vecs[5] = '{32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h8000_0000};

    reset              = 1'b1;
    redirect_en        = 1'b0;
    redirect_pc        = 32'h0;
    instr_ready        = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;

    // Reset state
    repeat (2) cycle(0, 32'h0);
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    reset  = 1'b0;
    exp_pc = RESET_PC;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("first_req_addr", bus.imem_req_addr, RESET_PC);

    // Streaming with 1-cycle memory
    repeat (20) cycle(0, 32'h0);
    chk("stream_throughput", 32'(pop_cnt >= 10), 32'h1);
    $display("stream: %0d instructions delivered, last pc %h", pop_cnt, last_pop_pc);

    // Decode stall for 10 cycles
    ir_pct = 0;
    h0     = req_hs_cnt;
    repeat (10) cycle(0, 32'h0);
    chk("stall_req_count", 32'(req_hs_cnt - h0 <= QDEPTH), 32'h1);
    #1;
    chk("stall_instr_valid", 32'(instr_valid), 32'h1);
    ir_pct = 100;
    p0     = pop_cnt;
    repeat (10) cycle(0, 32'h0);
    chk("stall_release_pops", 32'(pop_cnt - p0 >= QDEPTH), 32'h1);
    $display("stall: %0d requests during stall, %0d pops after release", req_hs_cnt - h0, pop_cnt - p0);

    // Redirect target alignment and wrap table
    for (int i = 0; i < 6; i++) begin
      drain(5);
      cycle(1, vecs[i].rpc);
      #1;
      chk("vec_req_valid", 32'(bus.imem_req_valid), 32'h1);
      chk("vec_req_addr", bus.imem_req_addr, vecs[i].exp_addr);
      rdy_pct = 100;
      cycle(0, 32'h0);
      #1;
      chk("vec_next_addr", bus.imem_req_addr, vecs[i].exp_next);
      $display("vector %0d: redirect %h -> addr %h next %h", i, vecs[i].rpc, vecs[i].exp_addr, bus.imem_req_addr);
    end
    drain(6);

    // Two old-path requests inflight, then redirect to an unaligned target
    cycle(1, 32'h10);
    lat_min = 5; lat_max = 5; rdy_pct = 100;
    repeat (2) cycle(0, 32'h0);
    chk("inflight_two", 32'(memq.size()), 32'd2);
    rdy_pct = 0;
    cycle(1, 32'h103);
    #1;
    chk("post_redirect_addr", bus.imem_req_addr, 32'h100);
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    p0 = pop_cnt; waited = 0;
    while (pop_cnt == p0 && waited < 40) begin
      cycle(0, 32'h0);
      waited++;
    end
    chk("redirect_first_pc", last_pop_pc, 32'h100);
    $display("drop: first instruction after redirect pc %h", last_pop_pc);

    // Redirect coinciding with a response and a request handshake
    arm_pc = 32'h200; arm_both = 1; armed_fired = 0; waited = 0;
    while (!armed_fired && waited < 50) begin
      cycle(0, 32'h0);
      waited++;
    end
    arm_both = 0;
    chk("coincident_redirect_seen", 32'(armed_fired), 32'h1);
    p0 = pop_cnt; waited = 0;
    while (pop_cnt == p0 && waited < 40) begin
      cycle(0, 32'h0);
      waited++;
    end
    chk("coincident_first_pc", last_pop_pc, 32'h200);
    repeat (10) cycle(0, 32'h0);
    $display("coincident redirect: resumed at pc %h", last_pop_pc);

    // Randomized traffic with random redirects
    rdy_pct = 70; ir_pct = 60; lat_min = 1; lat_max = 3;
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      bit          rd;
      rd  = ($urandom_range(39) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(rd, rpc);
    end
    chk("random_progress", 32'(pop_cnt - p0 > 200), 32'h1);
    $display("random: %0d instructions checked", pop_cnt - p0);

    // Reset with the queue full
    rdy_pct = 100; ir_pct = 0; lat_min = 1; lat_max = 1;
    repeat (6) cycle(0, 32'h0);
    #1;
    chk("full_before_reset", 32'(instr_valid), 32'h1);
    reset = 1'b1;
    cycle(0, 32'h0);
    #1;
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("midrst_instr_valid", 32'(instr_valid), 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    reset  = 1'b0;
    exp_pc = RESET_PC;
    #1;
    chk("postrst_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("postrst_req_addr", bus.imem_req_addr, RESET_PC);
    ir_pct = 100;
    p0 = pop_cnt;
    repeat (10) cycle(0, 32'h0);
    chk("postrst_pops", 32'(pop_cnt - p0 >= 4), 32'h1);
    $display("reset: restarted at %h, %0d instructions after release", RESET_PC, pop_cnt - p0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
